// File: rtl/ql_kbd_ipc.sv
// Keyboard-side IPC controller: drains the PS/2 keycode FIFO into a local ring buffer and answers
// IPC keyboard commands with framed replies. Autorepeat timer built only with QL_KBD_AUTOREPEAT_EN.
module ql_kbd_ipc #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned MAX_KEYS     = 7,
   parameter int unsigned REPEAT_DELAY = 500
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       tick,
   input  logic       kbd_available,
   input  logic [8:0] kbd_code,
   input  logic       kbd_pressed,
   output logic       kbd_strobe,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_last
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {FIdle, FStb, FGap1, FGap2} fill_e;
   typedef enum logic [2:0] {RIdle, RHdr, RMod, RKey, ROne} rsp_e;

   fill_e           fill_q, fill_d;
   rsp_e            rsp_q, rsp_d;
   logic [8:0]      mem_q [DEPTH];
   logic [8:0]      mem_d [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic [2:0]      rem_q, rem_d;
   logic [7:0]      one_q, one_d;
   logic            held_lat_q, held_lat_d;
   logic            rdy_q;
   logic            wr_en, pop, held, cmd_fire, rsp_fire;
   logic [2:0]      n_new;
   logic [8:0]      head;

`ifdef QL_KBD_AUTOREPEAT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!kbd_pressed || wr_en) begin
         cnt_d = '0;
      end else if (tick && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign held = (32'(cnt_q) >= REPEAT_DELAY);
`else
   logic unused_autorepeat;
   assign unused_autorepeat = tick ^ kbd_pressed;
   assign held = 1'b0;
`endif

   assign head     = mem_q[rptr_q];
   assign wr_en    = (fill_q == FIdle) && kbd_available && (occ_q != CW'(DEPTH));
   assign cmd_ready = rdy_q && (rsp_q == RIdle);
   assign cmd_fire = cmd_valid && cmd_ready;
   assign rsp_valid = (rsp_q != RIdle);
   assign rsp_fire = rsp_valid && rsp_ready;
   assign pop      = (rsp_q == RKey) && rsp_fire;
   assign kbd_strobe = (fill_q == FStb);
   assign n_new    = (32'(occ_q) > MAX_KEYS) ? 3'(MAX_KEYS) : 3'(occ_q);

   // Fill side: one capture per four cycles so the upstream FIFO pointer can settle.
   always_comb begin
      fill_d = fill_q;
      unique case (fill_q)
         FIdle: if (wr_en) fill_d = FStb;
         FStb:  fill_d = FGap1;
         FGap1: fill_d = FGap2;
         FGap2: fill_d = FIdle;
         default: fill_d = FIdle;
      endcase
   end

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (wr_en) begin
         mem_d[wptr_q] = kbd_code;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
         occ_d = occ_q + CW'(1);
      end else if (pop && !wr_en) begin
         occ_d = occ_q - CW'(1);
      end
   end

   always_comb begin
      rsp_d      = rsp_q;
      rem_d      = rem_q;
      one_d      = one_q;
      held_lat_d = held_lat_q;
      unique case (rsp_q)
         RIdle: begin
            if (cmd_fire) begin
               // Held is latched so the header byte stays stable while the consumer stalls.
               held_lat_d = held;
               if (cmd == 4'h8) begin
                  rem_d = n_new;
                  rsp_d = RHdr;
               end else if (cmd == 4'h1) begin
                  one_d = {6'b0, held, (occ_q != '0)};
                  rsp_d = ROne;
               end else begin
                  one_d = 8'h00;
                  rsp_d = ROne;
               end
            end
         end
         RHdr: if (rsp_ready) rsp_d = (rem_q == 3'd0) ? RIdle : RMod;
         RMod: if (rsp_ready) rsp_d = RKey;
         RKey: begin
            if (rsp_ready) begin
               rem_d = rem_q - 3'd1;
               rsp_d = (rem_q == 3'd1) ? RIdle : RMod;
            end
         end
         ROne: if (rsp_ready) rsp_d = RIdle;
         default: rsp_d = RIdle;
      endcase
   end

   always_comb begin
      rsp_data = 8'h00;
      rsp_last = 1'b0;
      unique case (rsp_q)
         RIdle: ;
         RHdr: begin
            rsp_data = {4'b0, held_lat_q, rem_q};
            rsp_last = (rem_q == 3'd0);
         end
         RMod: rsp_data = {5'b0, head[8:6]};
         RKey: begin
            rsp_data = {2'b0, head[5:0]};
            rsp_last = (rem_q == 3'd1);
         end
         ROne: begin
            rsp_data = one_q;
            rsp_last = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         fill_q     <= FIdle;
         rsp_q      <= RIdle;
         wptr_q     <= '0;
         rptr_q     <= '0;
         occ_q      <= '0;
         rem_q      <= '0;
         one_q      <= '0;
         held_lat_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         fill_q     <= fill_d;
         rsp_q      <= rsp_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         occ_q      <= occ_d;
         rem_q      <= rem_d;
         one_q      <= one_d;
         held_lat_q <= held_lat_d;
         rdy_q      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ql_kbd_ipc.sv
// Scoreboard bench for ql_kbd_ipc: stimulus queues expected reply bytes, a monitor compares them
// as the DUT transfers each byte. Expected held-flag values follow QL_KBD_AUTOREPEAT_EN.
module tb_ql_kbd_ipc;

   localparam int unsigned RD = 5;
`ifdef QL_KBD_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       tick = 1'b0;
   logic       kbd_available = 1'b0;
   logic [8:0] kbd_code = '0;
   logic       kbd_pressed = 1'b0;
   logic       kbd_strobe;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       rsp_last;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [8:0] ksrc[$];
   int         kidx = 0;
   int         strobes = 0;
   logic [8:0] exp_q[$];
   int         exp_idx = 0;

   logic [8:0] keys [9] = '{9'h003, 9'h048, 9'h08D, 9'h0D2, 9'h117, 9'h15C, 9'h1A1, 9'h1E6,
                           9'h02B};

   ql_kbd_ipc #(
      .DEPTH       (8),
      .MAX_KEYS    (7),
      .REPEAT_DELAY(RD)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .tick         (tick),
      .kbd_available(kbd_available),
      .kbd_code     (kbd_code),
      .kbd_pressed  (kbd_pressed),
      .kbd_strobe   (kbd_strobe),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd          (cmd),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_last     (rsp_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            if (exp_idx >= exp_q.size()) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: got %h last %b, expected no byte", rsp_data, rsp_last);
            end else begin
               check($sformatf("rsp_byte[%0d]", exp_idx), {rsp_last, rsp_data}, exp_q[exp_idx]);
               exp_idx++;
            end
         end
      end
   endtask

   // Upstream keyboard FIFO: head presented until strobed.
   task automatic kbd_model();
      forever begin
         @(negedge clk);
         if (kbd_strobe) begin
            strobes++;
            kidx++;
         end
         kbd_available = (kidx < ksrc.size());
         kbd_code      = kbd_available ? ksrc[kidx] : 9'h000;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input logic [7:0] b, input logic last);
      exp_q.push_back({last, b});
   endtask

   task automatic send_cmd(input logic [3:0] c);
      bit ok = 1'b0;
      cmd       = c;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("cmd_accepted", {8'h0, ok}, 9'h001);
      check("rsp_valid_after_cmd", {8'h0, rsp_valid}, 9'h001);
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((exp_idx == exp_q.size()) && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      cyc(1);
      check("reply_done", {8'h0, ok}, 9'h001);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      fork
         monitor();
         kbd_model();
      join_none

      // Reset state
      cyc(3);
      @(negedge clk);
      check("rst_strobe", {8'h0, kbd_strobe}, 9'h000);
      check("rst_cmd_ready", {8'h0, cmd_ready}, 9'h000);
      check("rst_rsp_valid", {8'h0, rsp_valid}, 9'h000);
      check("rst_rsp", {rsp_last, rsp_data}, 9'h000);
      cyc(1);
      nreset = 1'b1;
      cyc(1);
      check("cmd_ready_after_rst", {8'h0, cmd_ready}, 9'h001);

      // Read with an empty buffer
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h8);
      wait_done();

      // Two keys, strobe timing
      ksrc.push_back(9'h11C);
      @(negedge clk);
      @(negedge clk);
      check("strobe_high", {8'h0, kbd_strobe}, 9'h001);
      @(negedge clk);
      check("strobe_one_cycle", {8'h0, kbd_strobe}, 9'h000);
      ksrc.push_back(9'h02C);
      cyc(12);
      expect_byte(8'h02, 1'b0);
      expect_byte(8'h04, 1'b0);
      expect_byte(8'h1C, 1'b0);
      expect_byte(8'h00, 1'b0);
      expect_byte(8'h2C, 1'b1);
      send_cmd(4'h8);
      wait_done();
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h1);
      wait_done();

      // Nine keys upstream: buffer holds eight, read caps at seven
      s0 = strobes;
      for (int i = 0; i < 9; i++) ksrc.push_back(keys[i]);
      cyc(60);
      check("strobes_when_full", 9'(strobes - s0), 9'd8);
      check("upstream_keeps_key", {8'h0, kbd_available}, 9'h001);
      expect_byte(8'h01, 1'b1);
      send_cmd(4'h1);
      wait_done();
      expect_byte(8'h07, 1'b0);
      for (int i = 0; i < 7; i++) begin
         expect_byte({5'b0, keys[i][8:6]}, 1'b0);
         expect_byte({2'b0, keys[i][5:0]}, (i == 6));
      end
      send_cmd(4'h8);
      wait_done();
      cyc(20);
      expect_byte(8'h02, 1'b0);
      for (int i = 7; i < 9; i++) begin
         expect_byte({5'b0, keys[i][8:6]}, 1'b0);
         expect_byte({2'b0, keys[i][5:0]}, (i == 8));
      end
      send_cmd(4'h8);
      wait_done();

      // Stall in the modifier byte; a key arriving mid-reply waits for the next read
      ksrc.push_back(9'h0A5);
      cyc(10);
      rsp_ready = 1'b0;
      expect_byte(8'h01, 1'b0);
      expect_byte(8'h02, 1'b0);
      expect_byte(8'h25, 1'b1);
      send_cmd(4'h8);
      rsp_ready = 1'b1;
      cyc(1);
      rsp_ready = 1'b0;
      ksrc.push_back(9'h03F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_mod_byte", {rsp_last, rsp_data}, 9'h002);
         check("stall_valid", {8'h0, rsp_valid}, 9'h001);
      end
      cyc(1);
      rsp_ready = 1'b1;
      wait_done();
      cyc(6);
      expect_byte(8'h01, 1'b0);
      expect_byte(8'h00, 1'b0);
      expect_byte(8'h3F, 1'b1);
      send_cmd(4'h8);
      wait_done();

      // Autorepeat held flag
      kbd_pressed = 1'b1;
      cyc(2);
      for (int i = 0; i < RD - 1; i++) begin
         tick = 1'b1;
         cyc(1);
         tick = 1'b0;
         cyc(2);
      end
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h1);
      wait_done();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
      expect_byte(AR ? 8'h02 : 8'h00, 1'b1);
      send_cmd(4'h1);
      wait_done();
      expect_byte(AR ? 8'h08 : 8'h00, 1'b1);
      send_cmd(4'h8);
      wait_done();
      kbd_pressed = 1'b0;
      cyc(2);
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h1);
      wait_done();
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h3);
      wait_done();

      // Reset in the middle of a key byte
      ksrc.push_back(9'h1C1);
      ksrc.push_back(9'h042);
      cyc(12);
      rsp_ready = 1'b0;
      expect_byte(8'h02, 1'b0);
      expect_byte(8'h07, 1'b0);
      send_cmd(4'h8);
      rsp_ready = 1'b1;
      cyc(2);
      rsp_ready = 1'b0;
      @(negedge clk);
      check("in_key_byte", {rsp_last, rsp_data}, 9'h001);
      cyc(1);
      nreset = 1'b0;
      cyc(1);
      check("rst_mid_valid", {8'h0, rsp_valid}, 9'h000);
      check("rst_mid_strobe", {8'h0, kbd_strobe}, 9'h000);
      nreset = 1'b1;
      rsp_ready = 1'b1;
      cyc(2);
      expect_byte(8'h00, 1'b1);
      send_cmd(4'h8);
      wait_done();

      check("all_bytes_seen", 9'(exp_q.size() - exp_idx), 9'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ql_kbd_ipc.md
# ql_kbd_ipc

Keyboard-side controller for the QL IPC emulation: drains the PS/2 keyboard keycode FIFO into a local buffer, and answers IPC keyboard commands from the 68008-side IPC link with a framed byte stream (header, then modifier/key byte pairs). Sits between the `keyboard` block (strobe-popped 9-bit keycode FIFO plus `pressed` level) and the IPC command/response serialiser. Also generates the autorepeat "key held" flag.

## Interface
Parameters:
- `DEPTH`, 8: local keycode buffer entries (power of 2).
- `MAX_KEYS`, 7: max keys reported per read reply (≤7, fits 3-bit count).
- `REPEAT_DELAY`, 500: `tick` pulses of continuous press before held flag sets.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `nreset` in 1: synchronous, active-low reset.
- `tick` in 1: one-cycle timebase pulse (1 kHz nominal) for autorepeat timer.
- `kbd_available` in 1: keyboard FIFO non-empty.
- `kbd_code` in 9: FIFO head, {shift, ctrl, alt, keycode[5:0]}.
- `kbd_pressed` in 1: a key is currently held.
- `kbd_strobe` out 1: FIFO pop; one-cycle high pulse.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd` in 4: IPC command handshake.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out 8, `rsp_last` out 1: response byte stream.

## Operation
- Fill FSM: F_IDLE → F_STB → F_GAP1 → F_GAP2 → F_IDLE.
  - F_IDLE: if `kbd_available` and buffer not full: write `kbd_code` into buffer, go F_STB.
  - F_STB: `kbd_strobe`=1 for exactly this cycle.
  - F_GAP1/F_GAP2: strobe low; `kbd_available` ignored (upstream pointer settle).
  - Buffer full: stay F_IDLE; upstream FIFO keeps keys.
- Buffer: circular, `DEPTH` entries, wptr/rptr plus occupancy count 0..DEPTH. Write and pop in the same cycle are legal; occupancy unchanged.
- Response FSM: R_IDLE, R_HDR, R_MOD, R_KEY, R_ONE.
  - R_IDLE: `cmd_ready`=1. On `cmd_valid`:
    - `cmd`=4'h8: latch n = min(occupancy, MAX_KEYS), go R_HDR.
    - `cmd`=4'h1: go R_ONE with byte {6'b0, held, occupancy≠0}.
    - any other: go R_ONE with byte 8'h00.
  - R_HDR: byte {4'b0, held, n[2:0]}; `rsp_last`=(n==0). On accept: n==0 → R_IDLE, else R_MOD.
  - R_MOD: byte {5'b0, head[8:6]} (bit2 shift, bit1 ctrl, bit0 alt). On accept → R_KEY.
  - R_KEY: byte {2'b0, head[5:0]}; `rsp_last`=(remaining==1). On accept: pop buffer, decrement remaining; 0 → R_IDLE, else R_MOD.
  - R_ONE: `rsp_last`=1; on accept → R_IDLE.
- n latched at header; keys arriving mid-reply stay buffered for the next read.
- Autorepeat: 16-bit saturating counter; cleared when `kbd_pressed`=0 or on any buffer write; incremented on `tick` while pressed. held = (counter ≥ REPEAT_DELAY).

## Timing
- Reset values: `kbd_strobe`=0, `cmd_ready`=0 during reset then 1, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, buffer empty, counter 0, FSMs F_IDLE/R_IDLE.
- Command accepted cycle N → `rsp_valid`=1 with first byte at N+1.
- Byte transfers when `rsp_valid`&`rsp_ready`; next byte valid following cycle; `rsp_data`/`rsp_last` stable while `rsp_valid`&!`rsp_ready`.
- Fill: available at cycle N → strobe at N+1; earliest next capture N+4 (1 pop per 4 cycles).
- Reset mid-operation: all state cleared next edge; partial reply discarded, strobe forced low.

## Configuration
- `QL_KBD_AUTOREPEAT_EN` defined: counter and held flag as above.
- Not defined: counter absent; held constant 0 (header bit3 and status bit1 always 0); `tick` unused.

## Test plan
- Reset then `cmd`=8 with empty buffer → single byte 8'h00, `rsp_last`=1.
- Push codes 9'h11C (shift+a) and 9'h02C → `cmd`=8 yields 8'h02, 8'h04, 8'h1C, 8'h00, 8'h2C with `rsp_last` on last; buffer empty after.
- Enqueue 9 keys upstream → only 8 strobes until read; read returns header 8'h07 + 7 pairs; second read returns remaining 2 keys (8th buffered plus 9th refilled).
- Hold `rsp_ready`=0 for 5 cycles in R_MOD → data unchanged; key arriving mid-reply not counted, returned by next read.
- `kbd_pressed`=1 for REPEAT_DELAY ticks, then `cmd`=1 → 8'h02 (empty buffer) with macro; 8'h00 without; release clears.
- Deassert `nreset` during R_KEY → `rsp_valid`=0 next cycle, next `cmd`=8 returns 8'h00.
